// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic plus iterative signed multiply and divide
// behind a start/busy/done handshake. RC holds {HI, LO}.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     ry_in,
  input  logic [WIDTH-1:0]     rb_in,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   RC
);

  localparam logic [4:0] OpLdw  = 5'b00000, OpLdwi = 5'b00001, OpStw  = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011, OpSub  = 5'b00100, OpShr  = 5'b00101;
  localparam logic [4:0] OpShl  = 5'b00110, OpRor  = 5'b00111, OpRol  = 5'b01000;
  localparam logic [4:0] OpAnd  = 5'b01001, OpOr   = 5'b01010, OpAddi = 5'b01011;
  localparam logic [4:0] OpAndi = 5'b01100, OpOri  = 5'b01101, OpMul  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111, OpNeg  = 5'b10000, OpNot  = 5'b10001;
  localparam logic [SHW-1:0] LastIter = {SHW{1'b1}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

  state_e               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;    // mul: {hi, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0]     mag_q, mag_d;    // multiplicand or divisor magnitude
  logic                 sign_q, sign_d;  // product/quotient sign
  logic                 rneg_q, rneg_d;  // remainder sign (dividend sign)
  logic [2*WIDTH-1:0]   rc_q, rc_d;
  logic                 dbz_q, dbz_d;

  logic [SHW-1:0]       shamt;
  logic [2*WIDTH-1:0]   dbl_a, ror_w, rol_w;
  logic [WIDTH-1:0]     alu_lo, a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, mul_res;
  logic [WIDTH-1:0]     quo_res, rem_res;

  assign shamt = rb_in[SHW-1:0];
  assign dbl_a = {ry_in, ry_in};
  assign ror_w = dbl_a >> shamt;
  assign rol_w = dbl_a << shamt;
  assign a_mag = ry_in[WIDTH-1] ? ('0 - ry_in) : ry_in;
  assign b_mag = rb_in[WIDTH-1] ? ('0 - rb_in) : rb_in;

  always_comb begin
    alu_lo = '0;
    case (opcode)
      OpLdw, OpLdwi, OpStw, OpAdd, OpAddi: alu_lo = ry_in + rb_in;
      OpSub:         alu_lo = ry_in - rb_in;
      OpAnd, OpAndi: alu_lo = ry_in & rb_in;
      OpOr, OpOri:   alu_lo = ry_in | rb_in;
      OpShr:         alu_lo = ry_in >> shamt;
      OpShl:         alu_lo = ry_in << shamt;
      OpRor:         alu_lo = ror_w[WIDTH-1:0];
      OpRol:         alu_lo = rol_w[2*WIDTH-1:WIDTH];
      OpNeg:         alu_lo = '0 - rb_in;
      OpNot:         alu_lo = ~rb_in;
      default:       alu_lo = '0;
    endcase
  end

  // One shift-add step: add multiplicand to HI when the multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_res  = sign_q ? ('0 - mul_next) : mul_next;

  // One restoring-division step; rem_diff[WIDTH] is the borrow.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, mag_q};
  assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo_res  = sign_q ? ('0 - div_next[WIDTH-1:0]) : div_next[WIDTH-1:0];
  assign rem_res  = rneg_q ? ('0 - div_next[2*WIDTH-1:WIDTH]) : div_next[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    rneg_d  = rneg_q;
    rc_d    = rc_q;
    dbz_d   = dbz_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d  = '0;
          sign_d = ry_in[WIDTH-1] ^ rb_in[WIDTH-1];
          rneg_d = ry_in[WIDTH-1];
          if (opcode == OpMul) begin
            state_d = StMul;
            mag_d   = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
          end else if (opcode == OpDiv && rb_in == '0) begin
            state_d = StFin;
            rc_d    = {ry_in, {WIDTH{1'b1}}};
            dbz_d   = 1'b1;
          end else if (opcode == OpDiv) begin
            state_d = StDiv;
            mag_d   = b_mag;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
          end else begin
            state_d = StFin;
            rc_d    = {{WIDTH{1'b0}}, alu_lo};
            dbz_d   = 1'b0;
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StFin;
          rc_d    = mul_res;
          dbz_d   = 1'b0;
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StFin;
          rc_d    = {rem_res, quo_res};
          dbz_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      rneg_q  <= 1'b0;
      rc_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      rneg_q  <= rneg_d;
      rc_q    <= rc_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == StMul) || (state_q == StDiv);
  assign done        = (state_q == StFin);
  assign div_by_zero = dbz_q;
  assign RC          = rc_q;

endmodule
